// File: rtl/q_enc_gen_if.sv
// Register-write bus for the quadrature encoder generator.
// The CPU side drives it through the master modport; the generator samples it through the slave modport.
interface q_enc_gen_if;
  logic        write;
  logic [1:0]  addr;
  logic [1:0]  be;
  logic [15:0] data;

  modport master (output write, addr, be, data);
  modport slave  (input  write, addr, be, data);
endinterface

// File: rtl/q_enc_gen.sv
// Quadrature encoder emulator: walks a 32-bit position toward a written target and emits A/B/Z.
// It takes one count per programmable interval.
module q_enc_gen #(
  parameter logic [15:0] DEF_PERIOD = 16'd16,
  parameter logic [15:0] DEF_CPR    = 16'd0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               sclr,
  input  logic               ena,
  input  logic               dir,
  q_enc_gen_if.slave         bus,
  output logic               A,
  output logic               B,
  output logic               Z,
  output logic signed [31:0] position,
  output logic               busy,
  output logic               arrived
);

  logic signed [31:0] target;
  logic [15:0]        stage;
  logic [15:0]        period;
  logic [15:0]        cpr;
  logic [15:0]        idx;
  logic [15:0]        timer;

  logic               wr_stage, wr_target, wr_period, wr_cpr;
  logic [15:0]        last_tick;
  logic               active, step, move_up;
  logic signed [31:0] pos_next;
  logic signed [31:0] target_next;
  logic [15:0]        idx_next;
  logic [1:0]         phase;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din,
                                        input logic [1:0] en);
    return {en[1] ? din[15:8] : old[15:8], en[0] ? din[7:0] : old[7:0]};
  endfunction

  // Gray sequence {A,B} for position[1:0]; A leads B when counting up.
  function automatic logic [1:0] quad(input logic [1:0] p);
    logic [1:0] ab;
    case (p)
      2'b00:   ab = 2'b00;
      2'b01:   ab = 2'b10;
      2'b10:   ab = 2'b11;
      default: ab = 2'b01;
    endcase
    return ab;
  endfunction

  always_comb begin
    wr_stage  = bus.write && (bus.addr == 2'd0);
    wr_target = bus.write && (bus.addr == 2'd1);
    wr_period = bus.write && (bus.addr == 2'd2);
    wr_cpr    = bus.write && (bus.addr == 2'd3);

    // A period of 0 behaves like 1, so the fastest rate is one count per clock.
    last_tick = (period == 16'd0) ? 16'd0 : period - 16'd1;
    active    = ena && busy;
    step      = active && (timer >= last_tick);
    move_up   = target > position;

    pos_next = position;
    if (step)
      pos_next = move_up ? position + 32'sd1 : position - 32'sd1;

    target_next = target;
    if (wr_target)
      target_next = {merge(target[31:16], bus.data, bus.be), stage};

    // idx mirrors position modulo cpr; a cpr write re-origins it at the current position.
    idx_next = idx;
    if (wr_cpr)
      idx_next = 16'd0;
    else if (step && (cpr != 16'd0)) begin
      if (move_up)
        idx_next = (idx >= cpr - 16'd1) ? 16'd0 : idx + 16'd1;
      else
        idx_next = (idx == 16'd0) ? cpr - 16'd1 : idx - 16'd1;
    end

    phase = quad(position[1:0]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      position <= '0;
      target   <= '0;
      stage    <= '0;
      idx      <= '0;
      timer    <= '0;
      period   <= DEF_PERIOD;
      cpr      <= DEF_CPR;
      A        <= 1'b0;
      B        <= 1'b0;
      Z        <= 1'b0;
      busy     <= 1'b0;
      arrived  <= 1'b0;
    end else if (sclr) begin
      position <= '0;
      target   <= '0;
      stage    <= '0;
      idx      <= '0;
      timer    <= '0;
      A        <= 1'b0;
      B        <= 1'b0;
      Z        <= (cpr != 16'd0) && (idx == 16'd0);
      busy     <= 1'b0;
      arrived  <= 1'b0;
    end else begin
      timer    <= (!active || step) ? 16'd0 : timer + 16'd1;
      position <= pos_next;
      target   <= target_next;
      idx      <= idx_next;
      if (wr_stage)
        stage <= merge(stage, bus.data, bus.be);
      if (wr_period)
        period <= merge(period, bus.data, bus.be);
      if (wr_cpr)
        cpr <= merge(cpr, bus.data, bus.be);
      A        <= dir ? phase[0] : phase[1];
      B        <= dir ? phase[1] : phase[0];
      Z        <= (cpr != 16'd0) && (idx == 16'd0);
      busy     <= pos_next != target_next;
      arrived  <= step && (pos_next == target_next);
    end
  end

endmodule
